// File: rtl/clb_param_tile.sv
// clb_param_tile: parametrised CLB tile of LUT+FF elements with serial config chain and output gating until configured
module clb_param_tile #(
   parameter int NUM_FLE = 8,
   parameter int LUT_K   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     config_en,
   input  logic                     ccff_head,
   input  logic                     Test_en,
   input  logic [NUM_FLE*LUT_K-1:0] clb_I,
   input  logic                     clb_regin,
   input  logic                     clb_scin,
   output logic [2*NUM_FLE-1:0]     clb_O,
   output logic                     clb_regout,
   output logic                     clb_scout,
   output logic                     ccff_tail,
   output logic                     config_done
);
   localparam int CFG_W = (1 << LUT_K) + 2;
   localparam int CFG_TOTAL = NUM_FLE * CFG_W;
   localparam int CW = $clog2(CFG_TOTAL + 1);
   logic [CFG_TOTAL-1:0] cfg;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [NUM_FLE-1:0]   ff_q, ff_d, lut;
   logic [NUM_FLE:0]     reg_chain, scan_chain;
   assign reg_chain  = {ff_q, clb_regin};
   assign scan_chain = {ff_q, clb_scin};
   assign cnt_nxt = (config_en && cnt != CW'(CFG_TOTAL)) ? cnt + 1'b1 : cnt;
   assign ccff_tail  = cfg[CFG_TOTAL-1];
   assign clb_regout = config_done & ff_q[NUM_FLE-1];
   assign clb_scout  = config_done & ff_q[NUM_FLE-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg         <= '0;
         cnt         <= '0;
         config_done <= 1'b0;
         ff_q        <= '0;
      end else begin
         cnt         <= cnt_nxt;
         config_done <= cnt_nxt == CW'(CFG_TOTAL);
         if (config_en) cfg <= {cfg[CFG_TOTAL-2:0], ccff_head};
         else ff_q <= ff_d;
      end
   end
   for (genvar n = 0; n < NUM_FLE; n++) begin : g_fle
      logic                  out_sel, ff_src;
      logic [2**LUT_K-1:0]   mask;
      assign out_sel = cfg[n*CFG_W];
      assign ff_src  = cfg[n*CFG_W+1];
      assign mask    = cfg[n*CFG_W+2 +: 2**LUT_K];
      assign lut[n]  = mask[clb_I[n*LUT_K +: LUT_K]];
      assign ff_d[n] = Test_en ? scan_chain[n] : ff_src ? reg_chain[n] : lut[n];
      assign clb_O[2*n]   = config_done & (out_sel ? ff_q[n] : lut[n]);
      assign clb_O[2*n+1] = config_done & ff_q[n];
   end
endmodule

// File: tb/tb_clb_param_tile.sv
// tb_clb_param_tile: directed checks of config load, LUT, register/scan chains and gating (2 FLEs, 2-input LUTs)
module tb_clb_param_tile;
   logic       clk = 1'b0;
   logic       reset, config_en, ccff_head, Test_en, clb_regin, clb_scin;
   logic [3:0] clb_I;
   logic [3:0] clb_O;
   logic       clb_regout, clb_scout, ccff_tail, config_done;
   int         checks = 0;
   int         fails = 0;

   clb_param_tile #(.NUM_FLE(2), .LUT_K(2)) dut (
      .clk(clk), .reset(reset), .config_en(config_en), .ccff_head(ccff_head),
      .Test_en(Test_en), .clb_I(clb_I), .clb_regin(clb_regin), .clb_scin(clb_scin),
      .clb_O(clb_O), .clb_regout(clb_regout), .clb_scout(clb_scout),
      .ccff_tail(ccff_tail), .config_done(config_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load(input logic [11:0] v);
      config_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         ccff_head = v[i];
         tick();
      end
      config_en = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic test_reset();
      clb_I = 4'($urandom); clb_regin = 1'($urandom); clb_scin = 1'($urandom);
      Test_en = 1'($urandom); ccff_head = 1'b1; config_en = 1'b1;
      do_reset();
      config_en = 1'b0;
      #1;
      checks++; if (clb_O !== 4'h0) begin fails++; $display("FAIL reset_clb_O: got %h expected 0", clb_O); end
      checks++; if (clb_regout !== 1'b0) begin fails++; $display("FAIL reset_regout: got %b expected 0", clb_regout); end
      checks++; if (clb_scout !== 1'b0) begin fails++; $display("FAIL reset_scout: got %b expected 0", clb_scout); end
      checks++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL reset_tail: got %b expected 0", ccff_tail); end
      checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", config_done); end
      Test_en = 1'b0; clb_regin = 1'b0; clb_scin = 1'b0;
   endtask

   task automatic test_load_tail();
      logic [11:0] s;
      s = 12'b101100111000;
      do_reset();
      config_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         if (i == 6) begin
            config_en = 1'b0;
            tick(); tick(); tick();
            checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL pause_done: got %b expected 0", config_done); end
            config_en = 1'b1;
         end
         ccff_head = s[i];
         clb_I = 4'($urandom);
         tick();
         if (i > 0) begin
            checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL early_done bit %0d: got %b expected 0", 12 - i, config_done); end
            checks++; if (clb_O !== 4'h0) begin fails++; $display("FAIL gated_clb_O bit %0d: got %h expected 0", 12 - i, clb_O); end
         end
      end
      checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL load_done: got %b expected 1", config_done); end
      for (int j = 0; j < 12; j++) begin
         checks++; if (ccff_tail !== s[11-j]) begin fails++; $display("FAIL tail_echo %0d: got %b expected %b", j, ccff_tail, s[11-j]); end
         ccff_head = 1'b0;
         tick();
      end
      config_en = 1'b0;
      checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL done_after_extra: got %b expected 1", config_done); end
   endtask

   task automatic test_comb_lut();
      do_reset();
      load({6'b011000, 6'b100000});
      clb_I = 4'b0011; #1;
      checks++; if (clb_O[0] !== 1'b1) begin fails++; $display("FAIL and_11: got %b expected 1", clb_O[0]); end
      clb_I = 4'b0001; #1;
      checks++; if (clb_O[0] !== 1'b0) begin fails++; $display("FAIL and_01: got %b expected 0", clb_O[0]); end
      clb_I = 4'b0010; #1;
      checks++; if (clb_O[0] !== 1'b0) begin fails++; $display("FAIL and_10: got %b expected 0", clb_O[0]); end
      clb_I = 4'b0100; #1;
      checks++; if (clb_O[2] !== 1'b1) begin fails++; $display("FAIL xor_01: got %b expected 1", clb_O[2]); end
      clb_I = 4'b1100; #1;
      checks++; if (clb_O[2] !== 1'b0) begin fails++; $display("FAIL xor_11: got %b expected 0", clb_O[2]); end
      clb_I = 4'b1000; #1;
      checks++; if (clb_O[2] !== 1'b1) begin fails++; $display("FAIL xor_10: got %b expected 1", clb_O[2]); end
   endtask

   task automatic test_reg_chain();
      do_reset();
      clb_I = 4'b1111;
      load({6'b000010, 6'b000011});
      clb_regin = 1'b1; #1;
      checks++; if (clb_O[0] !== 1'b0) begin fails++; $display("FAIL reg_pre: got %b expected 0", clb_O[0]); end
      tick();
      checks++; if (clb_O[0] !== 1'b1) begin fails++; $display("FAIL reg_hop1_O0: got %b expected 1", clb_O[0]); end
      checks++; if (clb_O[3] !== 1'b0) begin fails++; $display("FAIL reg_hop1_O3: got %b expected 0", clb_O[3]); end
      tick();
      checks++; if (clb_O[3] !== 1'b1) begin fails++; $display("FAIL reg_hop2_O3: got %b expected 1", clb_O[3]); end
      checks++; if (clb_regout !== 1'b1) begin fails++; $display("FAIL reg_hop2_regout: got %b expected 1", clb_regout); end
      checks++; if (clb_scout !== 1'b1) begin fails++; $display("FAIL reg_hop2_scout: got %b expected 1", clb_scout); end
   endtask

   task automatic test_scan();
      logic [3:0] sin, sexp;
      sin = 4'b0101; sexp = 4'b1010;
      Test_en = 1'b1; clb_regin = 1'b1; clb_scin = 1'b0;
      tick(); tick();
      checks++; if (clb_scout !== 1'b0) begin fails++; $display("FAIL scan_flush: got %b expected 0", clb_scout); end
      for (int k = 0; k < 4; k++) begin
         clb_scin = sin[k];
         tick();
         checks++; if (clb_scout !== sexp[k]) begin fails++; $display("FAIL scan_step %0d: got %b expected %b", k, clb_scout, sexp[k]); end
      end
      clb_scin = 1'b1; config_en = 1'b1; ccff_head = 1'b0;
      tick();
      config_en = 1'b0;
      checks++; if (clb_scout !== 1'b1) begin fails++; $display("FAIL freeze_scout: got %b expected 1", clb_scout); end
      checks++; if (clb_O[1] !== 1'b0) begin fails++; $display("FAIL freeze_q0: got %b expected 0", clb_O[1]); end
      checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL freeze_done: got %b expected 1", config_done); end
      tick();
      checks++; if (clb_scout !== 1'b0) begin fails++; $display("FAIL unfreeze_scout: got %b expected 0", clb_scout); end
      checks++; if (clb_O[1] !== 1'b1) begin fails++; $display("FAIL unfreeze_q0: got %b expected 1", clb_O[1]); end
      Test_en = 1'b0; clb_scin = 1'b0; clb_regin = 1'b0;
   endtask

   task automatic test_reset_midload();
      do_reset();
      config_en = 1'b1; ccff_head = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL mid_done7: got %b expected 0", config_done); end
      reset = 1'b1;
      tick();
      reset = 1'b0; config_en = 1'b0;
      checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL mid_reset_done: got %b expected 0", config_done); end
      checks++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL mid_reset_tail: got %b expected 0", ccff_tail); end
      config_en = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL reload_done11: got %b expected 0", config_done); end
      checks++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL reload_tail11: got %b expected 0", ccff_tail); end
      tick();
      config_en = 1'b0;
      checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL reload_done12: got %b expected 1", config_done); end
      checks++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL reload_tail12: got %b expected 1", ccff_tail); end
   endtask

   initial begin
      reset = 1'b0; config_en = 1'b0; ccff_head = 1'b0; Test_en = 1'b0;
      clb_I = 4'h0; clb_regin = 1'b0; clb_scin = 1'b0;
      #1;
      test_reset();
      test_load_tail();
      test_comb_lut();
      test_reg_chain();
      test_scan();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/clb_param_tile.md
# clb_param_tile

Parametrised configurable logic block tile. It holds NUM_FLE fracturable logic elements, each built from a LUT_K-input LUT and a D flip-flop. Its configuration memory is a single shift chain loaded serially on the user clock. Register and scan chains are threaded through the FLEs. It sits in the tile array in place of the fixed 8-FLE CLB and adds parametrised width, on-chip configuration tracking and output gating until configuration completes.

## Interface
- NUM_FLE, default 8, number of FLEs (≥1).
- LUT_K, default 4, LUT inputs per FLE (2..6).
- Derived: CFG_W = 2^LUT_K + 2 bits per FLE; CFG_TOTAL = NUM_FLE*CFG_W.

Ports:
- clk  in  1  sole clock, used for both configuration shift and user logic.
- reset  in  1  synchronous, active-high.
- config_en  in  1  shift enable for the configuration chain.
- ccff_head  in  1  configuration serial in.
- Test_en  in  1  scan mode select.
- clb_I  in  NUM_FLE*LUT_K  LUT inputs; FLE n uses clb_I[n*LUT_K +: LUT_K], bit 0 is the LSB of the LUT index.
- clb_regin  in  1  register chain into FLE 0.
- clb_scin  in  1  scan chain into FLE 0.
- clb_O  out  2*NUM_FLE  FLE outputs.
- clb_regout  out  1  register chain out of FLE NUM_FLE-1.
- clb_scout  out  1  scan chain out.
- ccff_tail  out  1  configuration serial out.
- config_done  out  1  high once CFG_TOTAL bits have been shifted in.

## Operation
- Configuration register cfg[0:CFG_TOTAL-1]:
  - When config_en=1: cfg[0]<=ccff_head and cfg[i]<=cfg[i-1].
  - ccff_tail = cfg[CFG_TOTAL-1].
  - The first bit shifted in lands deepest, so the stream is sent last FLE, highest bit first.
- FLE n field, base b = n*CFG_W:
  - cfg[b] = out_sel (0 = combinational, 1 = registered).
  - cfg[b+1] = ff_src (0 = LUT, 1 = register chain).
  - cfg[b+2+j] = LUT mask bit j.
- LUT: lut_n = mask[idx], where idx is the FLE's clb_I slice.
- FF D input, priority order:
  - Test_en=1 → scan_in_n.
  - else ff_src=1 → regin_n.
  - else lut_n.
- Chain sources: scan_in_0 = clb_scin and regin_0 = clb_regin; for n>0 both are ff_q[n-1].
- FF enable: ff_q updates only when config_en=0. During a shift the FFs hold.
- Outputs, while config_done=1:
  - clb_O[2n] = out_sel ? ff_q[n] : lut_n.
  - clb_O[2n+1] = ff_q[n].
  - clb_regout = ff_q[NUM_FLE-1]; clb_scout = ff_q[NUM_FLE-1].
- Output gating: while config_done=0, clb_O, clb_regout and clb_scout are forced to 0. ccff_tail is never gated.
- Bit counter cnt, width clog2(CFG_TOTAL+1):
  - Increments on each clk edge with config_en=1.
  - Saturates at CFG_TOTAL.
  - config_done = (cnt == CFG_TOTAL), registered.
- Boundary cases:
  - config_en may drop mid-load; cnt holds and loading resumes later.
  - Shifts after done: cfg keeps shifting and done stays 1. Reloading therefore requires reset first.
  - reset mid-load: cfg, cnt and ff_q clear, and done=0.
  - reset together with config_en: reset wins.
  - Test_en together with config_en: config_en wins, so the FFs hold.

## Timing
- Reset values: cfg=0, cnt=0, ff_q=0, config_done=0, ccff_tail=0, clb_O=0, clb_regout=0, clb_scout=0.
- ccff_tail reproduces ccff_head CFG_TOTAL shift cycles later.
- config_done rises on the same edge that captures the CFG_TOTAL-th bit, i.e. it is visible in the cycle after that edge.
- Combinational path: clb_I → clb_O[2n] has zero latency when out_sel=0.
- Registered path: one cycle (clb_I → ff_q → clb_O).
- Register and scan chains: one cycle per FLE hop, so NUM_FLE cycles from clb_regin or clb_scin to clb_regout or clb_scout.

## Test plan
All scenarios use NUM_FLE=2, LUT_K=2, CFG_W=6, CFG_TOTAL=12.
- Reset: assert reset 2 cycles with random inputs → every output is 0 and config_done=0.
- Load and tail echo: shift 12 bits 101100111000 → config_done=1 after the 12th edge; ccff_tail replays the stream starting on edge 13; clb_O stays 0 before done.
- Combinational AND:
  - Configure FLE0 mask=4'b1000, out_sel=0.
  - clb_I[1:0]=2'b11 → clb_O[0]=1 in the same cycle.
  - clb_I[1:0]=2'b01 → clb_O[0]=0.
- Registered output and register chain:
  - Configure FLE0 out_sel=1, ff_src=1, and FLE1 ff_src=1.
  - Drive clb_regin=1 → clb_O[0]=1 after 1 edge; clb_O[3]=1 and clb_regout=1 after 2 edges.
- Scan: Test_en=1, clb_scin sequence 1,0,1 → clb_scout follows as 0(reset),0,1,0,1 with a 2-edge delay; config_en=1 during scan freezes the FFs.
- Reset mid-load: shift 7 bits, then pulse reset → cnt=0 and done=0. A further 12 shifts → done=1 on the 12th.
